// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store sequencer between the pipeline and a variable-latency data memory; 3+ cycles accept-to-idle (2 on error).
// Backpressure: req_ready is high only in IDLE, and mem_req holds all transaction fields stable until mem_ack or timeout.
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [2:0]  type_q, type_nxt;
    logic [1:0]  off_q, off_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        mem_req_nxt, mem_we_nxt, rsp_valid_nxt, rsp_err_nxt;
    logic [31:0] mem_addr_nxt, mem_wdata_nxt, rsp_data_nxt;
    logic [3:0]  mem_be_nxt;

    logic        illegal, misalign;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    function automatic logic [31:0] extract(input logic [2:0] t, input logic [1:0] b,
                                            input logic [31:0] w);
        logic [31:0] sh;
        logic [63:0] rot;
        logic [7:0]  by;
        logic [15:0] hw;
        logic [31:0] res;
        sh  = w >> {b, 3'b000};
        rot = {w, w} >> {b, 3'b000};
        by  = sh[7:0];
        hw  = b[1] ? w[31:16] : w[15:0];
        case (t)
            3'd1:    res = {{24{by[7]}}, by};
            3'd2:    res = {{16{hw[15]}}, hw};
            3'd3:    res = ($countones(by) == 4) ? {{24{by[7]}}, by} : 32'h0;
            3'd4:    res = rot[31:0];
            default: res = w;
        endcase
        return res;
    endfunction

    // Request decode: lw/sw and lh/sh share type codes, so alignment rules are direction-agnostic.
    always_comb begin
        illegal  = req_we ? (req_type > 3'd2) : (req_type > 3'd4);
        misalign = ((req_type == 3'd0) && (req_addr[1:0] != 2'b00)) ||
                   ((req_type == 3'd2) && req_addr[0]);
        st_be    = 4'b0000;
        st_wdata = 32'h0;
        if (req_we) begin
            case (req_type)
                3'd1: begin
                    st_be    = 4'b0001 << req_addr[1:0];
                    st_wdata = {4{req_wdata[7:0]}};
                end
                3'd2: begin
                    st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{req_wdata[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = req_wdata;
                end
            endcase
        end
    end

    always_comb begin
        state_nxt     = state;
        type_nxt      = type_q;
        off_nxt       = off_q;
        cnt_nxt       = cnt;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_be_nxt    = mem_be;
        mem_wdata_nxt = mem_wdata;
        rsp_valid_nxt = 1'b0;
        rsp_data_nxt  = rsp_data;
        rsp_err_nxt   = rsp_err;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    type_nxt = req_type;
                    off_nxt  = req_addr[1:0];
                    cnt_nxt  = 8'd0;
                    if (illegal || misalign) begin
                        state_nxt     = RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b1;
                        rsp_data_nxt  = 32'h0;
                    end else begin
                        state_nxt     = ISSUE;
                        mem_req_nxt   = 1'b1;
                        mem_we_nxt    = req_we;
                        mem_addr_nxt  = {req_addr[31:2], 2'b00};
                        mem_be_nxt    = st_be;
                        mem_wdata_nxt = st_wdata;
                    end
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    state_nxt     = RESP;
                    mem_req_nxt   = 1'b0;
                    cnt_nxt       = 8'd0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b0;
                    rsp_data_nxt  = mem_we ? 32'h0 : extract(type_q, off_q, mem_rdata);
                end else if (cnt == CNT_LAST) begin
                    state_nxt     = RESP;
                    mem_req_nxt   = 1'b0;
                    cnt_nxt       = 8'd0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                    rsp_data_nxt  = 32'h0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            type_q    <= 3'd0;
            off_q     <= 2'd0;
            cnt       <= 8'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            type_q    <= type_nxt;
            off_q     <= off_nxt;
            cnt       <= cnt_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_be    <= mem_be_nxt;
            mem_wdata <= mem_wdata_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

    assign req_ready = (state == IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: expected responses are queued at request time and
// matched when rsp_valid pulses; memory-side fields and timing are checked per ISSUE cycle.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_type;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data;

    int          total = 0;
    int          bad   = 0;
    logic [32:0] exp_q[$];
    logic [32:0] exp_e;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_type(req_type), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every response pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_e = exp_q.pop_front();
                check("rsp_data", rsp_data, exp_e[31:0]);
                check("rsp_err", 32'(rsp_err), 32'(exp_e[32]));
            end
        end
    end

    task automatic do_access(input string tag, input logic we, input logic [2:0] t,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                             input int ack_at, input int exp_cyc, input logic [3:0] exp_be,
                             input logic [31:0] exp_wd, input logic [31:0] exp_data,
                             input logic exp_err);
        int n;
        int w;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_type  = t;
        req_addr  = a;
        req_wdata = wd;
        exp_q.push_back({exp_err, exp_data});
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h5A5A_5A5A;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            if (!mem_req) break;
            n++;
            check({tag, "_addr"}, mem_addr, a & 32'hFFFF_FFFC);
            check({tag, "_we"}, 32'(mem_we), 32'(we));
            check({tag, "_be"}, 32'(mem_be), 32'(exp_be));
            if (we) check({tag, "_wdata"}, mem_wdata, exp_wd);
            mem_ack   = (i == ack_at);
            mem_rdata = (i == ack_at) ? rd : ~rd;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        check({tag, "_req_cycles"}, 32'(n), 32'(exp_cyc));
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        @(negedge clk);
        check({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
        check({tag, "_idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_type  = 3'd0;
        req_wdata = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        #3;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        //         tag        we    type  addr          wdata         rdata        ack cyc be       exp_wd        exp_data      err
        do_access("lb",       1'b0, 3'd1, 32'h0000_1003, 32'h0,        32'h80FF_1234, 1, 1, 4'b0000, 32'h0,        32'hFFFF_FF80, 1'b0);
        do_access("lw_mis",   1'b0, 3'd0, 32'h0000_5001, 32'h0,        32'h1111_1111, 1, 0, 4'b0000, 32'h0,        32'h0,         1'b1);
        do_access("ld_t5",    1'b0, 3'd5, 32'h0000_5000, 32'h0,        32'h1111_1111, 1, 0, 4'b0000, 32'h0,        32'h0,         1'b1);
        do_access("lboez_s",  1'b0, 3'd3, 32'h0000_2001, 32'h0,        32'h0000_F000, 2, 2, 4'b0000, 32'h0,        32'hFFFF_FFF0, 1'b0);
        do_access("lboez_z",  1'b0, 3'd3, 32'h0000_2001, 32'h0,        32'h0000_7000, 1, 1, 4'b0000, 32'h0,        32'h0,         1'b0);
        do_access("lboez_p",  1'b0, 3'd3, 32'h0000_2002, 32'h0,        32'h000F_0000, 1, 1, 4'b0000, 32'h0,        32'h0000_000F, 1'b0);
        do_access("lwrr2",    1'b0, 3'd4, 32'h0000_3002, 32'h0,        32'h1122_3344, 1, 1, 4'b0000, 32'h0,        32'h3344_1122, 1'b0);
        do_access("lwrr0",    1'b0, 3'd4, 32'h0000_3000, 32'h0,        32'h1122_3344, 3, 3, 4'b0000, 32'h0,        32'h1122_3344, 1'b0);
        do_access("lh_hi",    1'b0, 3'd2, 32'h0000_1002, 32'h0,        32'h8001_7FFF, 1, 1, 4'b0000, 32'h0,        32'hFFFF_8001, 1'b0);
        do_access("lh_lo",    1'b0, 3'd2, 32'h0000_1000, 32'h0,        32'h8001_7FFF, 1, 1, 4'b0000, 32'h0,        32'h0000_7FFF, 1'b0);
        do_access("lh_mis",   1'b0, 3'd2, 32'h0000_1003, 32'h0,        32'h8001_7FFF, 1, 0, 4'b0000, 32'h0,        32'h0,         1'b1);
        do_access("sh",       1'b1, 3'd2, 32'h0000_4002, 32'h0000_ABCD, 32'h0,       5, 5, 4'b1100, 32'hABCD_ABCD, 32'h0,         1'b0);
        do_access("sb",       1'b1, 3'd1, 32'h0000_7001, 32'h1234_5678, 32'h0,       1, 1, 4'b0010, 32'h7878_7878, 32'h0,         1'b0);
        do_access("sw",       1'b1, 3'd0, 32'h0000_7004, 32'hCAFE_F00D, 32'h0,       2, 2, 4'b1111, 32'hCAFE_F00D, 32'h0,         1'b0);
        do_access("lw",       1'b0, 3'd0, 32'h0000_6000, 32'h0,        32'hDEAD_BEEF, 1, 1, 4'b0000, 32'h0,        32'hDEAD_BEEF, 1'b0);
        do_access("sh_mis",   1'b1, 3'd2, 32'h0000_4001, 32'h0000_ABCD, 32'h0,       1, 0, 4'b0000, 32'h0,        32'h0,         1'b1);
        do_access("lw_ok",    1'b0, 3'd0, 32'h0000_6004, 32'h0,        32'h0BAD_F00D, 1, 1, 4'b0000, 32'h0,        32'h0BAD_F00D, 1'b0);
        do_access("st_t3",    1'b1, 3'd3, 32'h0000_4000, 32'h0000_ABCD, 32'h0,       1, 0, 4'b0000, 32'h0,        32'h0,         1'b1);
        do_access("lw_pre",   1'b0, 3'd0, 32'h0000_6008, 32'h0,        32'h7777_7777, 1, 1, 4'b0000, 32'h0,        32'h7777_7777, 1'b0);
        do_access("timeout",  1'b0, 3'd0, 32'h0000_8000, 32'h0,        32'h1234_5678, 0, 16, 4'b0000, 32'h0,       32'h0,         1'b1);

        // Stray acks while idle must not produce a response.
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_ack_rsp", 32'(rsp_valid), 32'd0);
            check("idle_ack_ready", 32'(req_ready), 32'd1);
        end
        mem_ack = 1'b0;

        // Reset in the middle of a transaction.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_type  = 3'd0;
        req_addr  = 32'h0000_9000;
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_req_high", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_req", 32'(mem_req), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
            check("mid_rst_no_req", 32'(mem_req), 32'd0);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
